// File: rtl/memory_controller_if.sv
// Command/write/read bus for memory_controller.
// The master modport is the host sequencer; the slave modport is the controller.
interface memory_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  rw;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, rw
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, rw
    );
endinterface

// File: rtl/memory_controller.sv
// Burst read/write controller around a DATA_WIDTH x 2**ADDR_WIDTH array with wrapping address.
// Define MEMORY_CONTROLLER_CLEAR_EN to make rst also zero every array word.
module memory_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input logic               clk,
    input logic               rst,
    memory_controller_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  mem_we;
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ptr_d   = bus.cmd_addr;
                    cnt_d   = bus.cmd_len;
                    state_d = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                // A low wr_valid simply freezes pointer and counter.
                if (bus.wr_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + ONE;
                    cnt_d  = cnt_q - ONE;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                rd_en      = 1'b1;
                rd_valid_d = 1'b1;
                ptr_d      = ptr_q + ONE;
                cnt_d      = cnt_q - ONE;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array write port and registered read port share one process so the
    // read stays a synchronous RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
`ifdef MEMORY_CONTROLLER_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`endif
        end else begin
            if (mem_we) begin
                mem_q[ptr_q] <= bus.wr_data;
            end
            if (rd_en) begin
                rd_data_q <= mem_q[ptr_q];
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WRITE);
    assign bus.rw        = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: bursts, wrap-around, stalls, ignored commands, reset abort.
// Expectations follow MEMORY_CONTROLLER_CLEAR_EN when the bench is built with it.
module tb_memory_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    memory_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    memory_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] karl   [8] = '{8'h4B, 8'h61, 8'h72, 8'h6C, 8'h21, 8'h21, 8'h21, 8'h21};
    logic [7:0] wrap_w [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] wrap_0 [8] = '{8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] wrap_6 [8] = '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] seq1x  [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] seq3x  [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    logic [7:0] rot3x  [8] = '{8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h30, 8'h31, 8'h32};
    logic [7:0] zeros  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [2:0] len, input logic [7:0] d [8],
                            input int stall_after, input int stall_cycles);
        check("wr_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        check("wr_busy", bus.busy, 1);
        check("wr_rw", bus.rw, 1);
        check("wr_ready", bus.wr_ready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = d[i];
            step();
            if (i == stall_after) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'hEE;
                for (int s = 0; s < stall_cycles; s++) begin
                    step();
                    check("wr_stall_busy", bus.busy, 1);
                end
            end
        end
        bus.wr_valid = 1'b0;
        check("wr_done_busy", bus.busy, 0);
        check("wr_done_rw", bus.rw, 0);
        check("wr_done_cmd_ready", bus.cmd_ready, 1);
        $display("write addr=%0d len=%0d done", addr, len);
    endtask

    task automatic do_read(input logic [2:0] addr, input logic [2:0] len, input logic [7:0] e [8],
                           input int intrude_beat, input int abort_after);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        step();
        bus.cmd_valid = 1'b0;
        check("rd_busy", bus.busy, 1);
        check("rd_rw", bus.rw, 0);
        check("rd_valid_pre", bus.rd_valid, 0);
        for (int k = 0; k <= int'(len); k++) begin
            step();
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'b0;
            check($sformatf("rd_valid[%0d]", k), bus.rd_valid, 1);
            check($sformatf("rd_data[%0d]", k), bus.rd_data, e[k]);
            check($sformatf("rd_cmd_ready[%0d]", k), bus.cmd_ready, (k == int'(len)) ? 1 : 0);
            if (k == intrude_beat) begin
                // A write command offered mid-read must not be taken.
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 3'd0;
                bus.cmd_len   = 3'd7;
            end
            if (k == abort_after) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("abort_rd_valid", bus.rd_valid, 0);
                check("abort_cmd_ready", bus.cmd_ready, 1);
                check("abort_busy", bus.busy, 0);
                check("abort_rd_data", bus.rd_data, 0);
                $display("read addr=%0d len=%0d aborted after beat %0d", addr, len, k);
                return;
            end
        end
        step();
        check("rd_valid_post", bus.rd_valid, 0);
        check("rd_post_cmd_ready", bus.cmd_ready, 1);
        $display("read addr=%0d len=%0d done", addr, len);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        step();
        // Reset must win over a simultaneous command handshake.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        step();
        check("rst_override_busy", bus.busy, 0);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        rst = 1'b0;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rw", bus.rw, 0);
        $display("reset state checked");

        do_write(3'd0, 3'd7, karl, -1, 0);
        do_read(3'd0, 3'd7, karl, -1, -1);

        do_write(3'd6, 3'd3, wrap_w, -1, 0);
        do_read(3'd0, 3'd1, wrap_0, -1, -1);
        do_read(3'd6, 3'd1, wrap_6, -1, -1);

        do_write(3'd0, 3'd7, seq1x, 2, 3);
        do_read(3'd0, 3'd7, seq1x, -1, -1);

        do_read(3'd0, 3'd7, seq1x, 1, 3);
`ifdef MEMORY_CONTROLLER_CLEAR_EN
        do_read(3'd0, 3'd7, zeros, -1, -1);
`else
        do_read(3'd0, 3'd7, seq1x, -1, -1);
`endif

        do_write(3'd5, 3'd7, seq3x, -1, 0);
        do_read(3'd5, 3'd7, seq3x, -1, -1);
        do_read(3'd0, 3'd7, rot3x, -1, -1);

        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef MEMORY_CONTROLLER_CLEAR_EN
        do_read(3'd0, 3'd7, zeros, -1, -1);
`else
        do_read(3'd0, 3'd7, rot3x, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_controller.md
# memory_controller

Parametrised, handshaked controller wrapping a `DATA_WIDTH` x `2**ADDR_WIDTH` register-array memory. It replaces the bare read/write FSM plus fixed 8x8 memory pair. It accepts burst read and write commands, auto-increments the address with wrap-around, and streams data one beat per cycle. It sits between a test or host sequencer and on-chip storage, with the FSM and the array in one block.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per word.
- `ADDR_WIDTH`, 3: address bits; depth `DEPTH = 2**ADDR_WIDTH`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at an edge.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in `ADDR_WIDTH`: start address.
- `cmd_len` in `ADDR_WIDTH`: beats minus one (0 gives 1 beat; `DEPTH-1` gives full array).
- `wr_data` in `DATA_WIDTH`: write beat data.
- `wr_valid` in 1: write beat offered.
- `wr_ready` out 1: write beat taken when `wr_valid && wr_ready`.
- `rd_data` out `DATA_WIDTH`: read beat data, registered.
- `rd_valid` out 1: `rd_data` valid this cycle; no backpressure.
- `busy` out 1: burst in progress (state not IDLE).
- `rw` out 1: high while in WRITE state.

## Operation
- States: IDLE, WRITE, READ.
- IDLE: `cmd_ready=1`. On accept, the block latches `cmd_addr` into the address pointer and `cmd_len` into the beat counter. It moves to WRITE if `cmd_write`, else READ.
- WRITE:
  - `wr_ready=1`, `rw=1`.
  - Each handshake writes `mem[ptr] <= wr_data`, then `ptr++` and the counter decrements.
  - The beat taken with counter 0 returns the FSM to IDLE.
  - `wr_valid` low stalls the burst: no write, no pointer or counter change.
- READ:
  - Every cycle: `rd_data <= mem[ptr]`, `rd_valid <= 1`, then `ptr++` and the counter decrements.
  - The beat with counter 0 returns the FSM to IDLE.
  - In any other state `rd_valid <= 0`, and `rd_data` holds its last value.
- Pointer arithmetic is modulo `DEPTH`: `DEPTH-1` wraps to 0. A burst of `DEPTH` beats touches every word exactly once.
- `cmd_valid` outside IDLE is ignored (`cmd_ready=0`), with no side effects. Between bursts there is one IDLE cycle minimum.
- `wr_valid` outside WRITE is ignored.
- `rd_data`/`rd_valid` always come from the registered output; the array is never read combinationally to the port.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `wr_ready=0`, `rd_valid=0`, `rd_data=0`, `busy=0`, `rw=0`, pointer 0, counter 0.
- `rst` overrides everything, including a handshake in the same cycle.
- Reset mid-burst:
  - Abort the burst.
  - Outputs return to reset values at the next edge.
  - Words already written are retained, unless the Configuration macro is defined.
- Write: data is visible to any later read command from the edge after the handshake.
- Read: with the command accepted at edge E0, beat k is loaded at edge E(1+k) and `rd_valid` is high for cycles E1 through E(len+1).
  - `cmd_ready` rises after E(len+1).
  - `rd_valid` falls at E(len+2).
- Write burst minimum duration is len+1 cycles after accept (no stalls).

## Configuration
- `MEMORY_CONTROLLER_CLEAR_EN` defined: `rst` also clears every array word to 0 in the same edge.
- Undefined: array contents are untouched by `rst` (power-up X in simulation).

## Test plan
- Write addr 0, len 7, data 0x4B,0x61,0x72,0x6C,0x21,0x21,0x21,0x21 ("Karl!!!!"); read addr 0, len 7 -> `rd_valid` high 8 consecutive cycles with the same byte sequence.
- Wrap-around: write addr 6, len 3, data 0xA0..0xA3; read addr 0, len 1 -> 0xA2, 0xA3; read addr 6, len 1 -> 0xA0, 0xA1.
- Write stall: `wr_valid` low 3 cycles after beat 2 of an 8-beat burst -> `busy` stays 1, no extra writes, readback matches the input sequence.
- `cmd_valid` pulsed with a write to addr 0 during an active read -> `cmd_ready`=0 and memory unchanged. Reset asserted after read beat 3 -> `rd_valid`=0 and `cmd_ready`=1 the next cycle; a following full read returns the original data.
- Full-depth burst: write len `DEPTH-1` from addr 5 -> all `DEPTH` words written once; read back in order from addr 5.
- With `MEMORY_CONTROLLER_CLEAR_EN`: fill the array, assert reset, read addr 0, len 7 -> eight beats of 0x00.
